// File: rtl/video_capture.sv
// VDP capture front-end: turns raw pixel strobes and blanking into spaced per-pixel
// write strobes with x/y coordinates, and measures the active frame size every frame.
module video_capture #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int COLOR_BITS = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      ce_pix_in,
  input  logic                      hblank,
  input  logic                      vblank,
  input  logic [COLOR_BITS-1:0]     r_in,
  input  logic [COLOR_BITS-1:0]     g_in,
  input  logic [COLOR_BITS-1:0]     b_in,
  output logic                      ce_pix,
  output logic [COLOR_BITS-1:0]     r,
  output logic [COLOR_BITS-1:0]     g,
  output logic [COLOR_BITS-1:0]     b,
  output logic [$clog2(WIDTH)-1:0]  x,
  output logic [$clog2(HEIGHT)-1:0] y,
  output logic [10:0]               width,
  output logic [9:0]                height,
  output logic                      frame_end,
  output logic                      overflow,
  output logic                      err
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int LW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(HEIGHT + 1);

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_VBL  = 2'd1,
    S_ACT  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            hblank_r, vblank_r;
  logic [XW-1:0]   x_cnt;
  logic [YW-1:0]   y_cnt;
  logic [LW-1:0]   line_len, max_len, max_eol;
  logic [CW-1:0]   line_cnt, cnt_eol;
  logic            hb_rise, vb_rise, vb_fall;
  logic            cand, sat, acc, drop_space, drop_sat;
  logic            line_end, frame_latch, start;

  function automatic logic [XW-1:0] inc_x(input logic [XW-1:0] v);
    return (v == XW'(WIDTH - 1)) ? v : v + XW'(1);
  endfunction

  function automatic logic [YW-1:0] inc_y(input logic [YW-1:0] v);
    return (v == YW'(HEIGHT - 1)) ? v : v + YW'(1);
  endfunction

  function automatic logic [CW-1:0] inc_cnt(input logic [CW-1:0] v);
    return (v == CW'(HEIGHT)) ? v : v + CW'(1);
  endfunction

  function automatic logic [LW-1:0] max_of(input logic [LW-1:0] a, input logic [LW-1:0] c);
    return (a > c) ? a : c;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_SYNC;
    else         state <= state_nxt;
  end

  // ce_pix doubles as "accepted last cycle", which enforces the one-cycle gap downstream
  always_comb begin
    hb_rise     = hblank & ~hblank_r;
    vb_rise     = vblank & ~vblank_r;
    vb_fall     = ~vblank & vblank_r;
    cand        = ce_pix_in & ~hblank & ~vblank & (state == S_ACT);
    sat         = (line_len == LW'(WIDTH)) | (line_cnt == CW'(HEIGHT));
    acc         = cand & ~ce_pix & ~sat;
    drop_space  = cand & ce_pix;
    drop_sat    = cand & ~ce_pix & sat;
    line_end    = (state == S_ACT) & hb_rise & (line_len != '0);
    max_eol     = line_end ? max_of(max_len, line_len) : max_len;
    cnt_eol     = line_end ? inc_cnt(line_cnt) : line_cnt;
    frame_latch = (state == S_ACT) & vb_rise;
    start       = (state == S_VBL) & vb_fall;
    state_nxt   = state;
    case (state)
      S_SYNC:  if (vblank)      state_nxt = S_VBL;
      S_VBL:   if (vb_fall)     state_nxt = S_ACT;
      S_ACT:   if (vb_rise)     state_nxt = S_VBL;
      default:                  state_nxt = S_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hblank_r  <= 1'b0;
      vblank_r  <= 1'b0;
      ce_pix    <= 1'b0;
      r         <= '0;
      g         <= '0;
      b         <= '0;
      x         <= '0;
      y         <= '0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      line_len  <= '0;
      max_len   <= '0;
      line_cnt  <= '0;
      width     <= 11'(WIDTH);
      height    <= 10'(HEIGHT);
      frame_end <= 1'b0;
      overflow  <= 1'b0;
      err       <= 1'b0;
    end else begin
      hblank_r  <= hblank;
      vblank_r  <= vblank;
      ce_pix    <= acc;
      frame_end <= frame_latch;
      if (acc) begin
        r        <= r_in;
        g        <= g_in;
        b        <= b_in;
        x        <= x_cnt;
        y        <= y_cnt;
        x_cnt    <= inc_x(x_cnt);
        line_len <= line_len + LW'(1);
      end
      if (drop_sat)   overflow <= 1'b1;
      if (drop_space) err      <= 1'b1;
      if (hb_rise) begin
        x_cnt    <= '0;
        line_len <= '0;
      end
      if (line_end) begin
        max_len  <= max_eol;
        line_cnt <= cnt_eol;
        y_cnt    <= inc_y(y_cnt);
      end
      // Same-cycle line end is folded in through max_eol/cnt_eol
      if (frame_latch && cnt_eol != '0) begin
        width  <= 11'(max_eol);
        height <= 10'(cnt_eol);
      end
      if (start) begin
        x_cnt    <= '0;
        y_cnt    <= '0;
        line_len <= '0;
        max_len  <= '0;
        line_cnt <= '0;
      end
    end
  end

endmodule
